// File: rtl/fpu_unary_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-stallable unary FPU unit among NREQ requesters.
// Optional build macro FPU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority (higher indices may starve).
module fpu_unary_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDXW    = 2,
   parameter int LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [31:0]          fu_x,
   input  logic [31:0]          fu_y,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_data,
   output logic                 busy
);

   logic            grant_any;
   logic [IDXW-1:0] grant_idx;
   logic [31:0]     grant_data;
   logic [LATENCY:0] tag_valid;
   logic [IDXW-1:0]  tag_idx [0:LATENCY];

`ifdef FPU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!grant_any && req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = IDXW'(i);
         end
      end
   end
`else
   logic [IDXW-1:0]   ptr;
   logic [IDXW-1:0]   ptr_next;
   logic [2*NREQ-1:0] rotated;

   // Rotating a doubled copy puts requester ptr at bit 0, so the scan uses constant indices only.
   always_comb begin
      int unsigned pos;
      pos       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      rotated   = {req_valid, req_valid} >> ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!grant_any && rotated[k]) begin
            grant_any = 1'b1;
            pos       = 32'(ptr) + k;
            if (pos >= 32'(NREQ))
               pos = pos - 32'(NREQ);
            grant_idx = IDXW'(pos);
         end
      end
      ptr_next = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         ptr <= '0;
      else if (grant_any)
         ptr <= ptr_next;
   end
`endif

   always_comb begin
      req_ready  = '0;
      grant_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_any && grant_idx == IDXW'(i)) begin
            req_ready[i] = 1'b1;
            grant_data   = req_data[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         fu_x      <= '0;
         tag_valid <= '0;
         for (int unsigned k = 0; k <= LATENCY; k++)
            tag_idx[k] <= '0;
      end else begin
         tag_valid  <= {tag_valid[LATENCY-1:0], grant_any};
         tag_idx[0] <= grant_idx;
         for (int unsigned k = 1; k <= LATENCY; k++)
            tag_idx[k] <= tag_idx[k-1];
         if (grant_any)
            fu_x <= grant_data;
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         rsp_valid[i] = tag_valid[LATENCY] && (tag_idx[LATENCY] == IDXW'(i));
   end

   assign rsp_data = fu_y;
   assign busy     = |tag_valid;

endmodule

// File: tb/tb_fpu_unary_arbiter.sv
// Bench for fpu_unary_arbiter: behavioural floor unit plus a queue-based reference model of grants and responses.
module tb_fpu_unary_arbiter;
   localparam int NREQ = 4;
   localparam int IDXW = 2;
   localparam int LAT  = 1;

   logic                clk = 1'b0;
   logic                rstn;
   logic [NREQ-1:0]     req_valid;
   logic [32*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic [31:0]         fu_x;
   logic [31:0]         fu_y;
   logic [NREQ-1:0]     rsp_valid;
   logic [31:0]         rsp_data;
   logic                busy;

   fpu_unary_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .LATENCY(LAT)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fu_x(fu_x), .fu_y(fu_y), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] floor32(input logic [31:0] x);
      int unsigned e, n;
      logic [31:0] mask;
      e = {24'd0, x[30:23]};
      if (e >= 150) return x;
      if (e < 127) begin
         if (x[30:0] == 31'd0) return x;
         return x[31] ? 32'hBF80_0000 : 32'h0000_0000;
      end
      n    = 150 - e;
      mask = (32'd1 << n) - 32'd1;
      if ((x & mask) == 32'd0) return x;
      if (!x[31]) return x & ~mask;
      return (x & ~mask) + (32'd1 << n);
   endfunction

   // Shared unit: single-stage floor.
   always @(posedge clk) fu_y <= floor32(fu_x);

   typedef struct {
      int          idx;
      logic [31:0] d;
      int          due;
   } op_t;

   op_t         q[$];
   int          m_ptr = 0;
   logic [31:0] m_fux = 32'd0;
   int          cur = 0;
   int          last_grant = -1;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] obs_ready, obs_rsp, obs_data;
   logic        obs_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cur, got, exp);
      end
   endtask

   function automatic int model_grant();
`ifdef FPU_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++)
         if (req_valid[i]) return i;
`else
      for (int k = 0; k < NREQ; k++)
         if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
      return -1;
   endfunction

   // One clock cycle: check outputs at the negedge, then advance the model at the posedge.
   task automatic step();
      int g;
      logic [31:0] exp_rsp;
      @(negedge clk);
      g = model_grant();
      obs_ready = 32'(req_ready);
      obs_rsp   = 32'(rsp_valid);
      obs_busy  = busy;
      obs_data  = rsp_data;
      check("req_ready", obs_ready, (g < 0) ? 32'd0 : (32'd1 << g));
      check("busy", {31'd0, busy}, {31'd0, q.size() != 0});
      check("fu_x", fu_x, m_fux);
      exp_rsp = 32'd0;
      if (q.size() != 0 && q[0].due == cur) begin
         exp_rsp = 32'd1 << q[0].idx;
         check("rsp_data", rsp_data, floor32(q[0].d));
         void'(q.pop_front());
      end
      check("rsp_valid", obs_rsp, exp_rsp);
      @(posedge clk);
      if (!rstn) begin
         q.delete();
         m_ptr = 0;
         m_fux = 32'd0;
         g = -1;
      end else if (g >= 0) begin
         q.push_back('{idx: g, d: req_data[32*g +: 32], due: cur + LAT + 1});
         m_ptr = (g + 1) % NREQ;
         m_fux = req_data[32*g +: 32];
      end
      last_grant = g;
      cur++;
      #1;
   endtask

   function automatic logic [31:0] rand_float();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0:       return {r[31], 31'd0};
         1:       return {r[31], 8'($urandom_range(100, 126)), r[22:0]};
         default: return {r[31], 8'($urandom_range(127, 155)), r[22:0]};
      endcase
   endfunction

   task automatic drive_random();
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && last_grant != i) continue;
         if ($urandom_range(0, 2) != 0) begin
            req_valid[i] = 1'b1;
            req_data[32*i +: 32] = rand_float();
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   initial begin
      int busy_cycles;
      int gseq[8];
      rstn      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;

      // Reset state
      step();
      check("reset_rsp_idle", obs_rsp, 32'd0);

      // Single op: requester 2, 2.5 -> 2.0
      req_valid = 4'b0100;
      req_data[64 +: 32] = 32'h4020_0000;
      busy_cycles = 0;
      step();
      check("single_ready", obs_ready, 32'h4);
      req_valid = '0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (obs_busy) busy_cycles++;
         if (c == 1) begin
            check("single_rsp_valid", obs_rsp, 32'h4);
            check("single_rsp_data", obs_data, 32'h4000_0000);
         end
      end
      check("single_busy_cycles", 32'(busy_cycles), 32'd2);

      // Negative operand: requester 0, -1.5 -> -2.0
      req_valid = 4'b0001;
      req_data[0 +: 32] = 32'hBFC0_0000;
      step();
      req_valid = '0;
      step();
      step();
      check("neg_rsp_valid", obs_rsp, 32'h1);
      check("neg_rsp_data", obs_data, 32'hC000_0000);
      step();

      // Contention: all valid from reset
      rstn = 1'b0;
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h3FC0_0000 + 32'(i) * 32'h0080_0000;
      step();
      rstn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         gseq[c] = last_grant;
      end
`ifndef FPU_ARB_FIXED_PRIO_EN
      for (int c = 0; c < 8; c++) check("contention_order", 32'(gseq[c]), 32'(c % NREQ));
`endif
      req_valid = '0;
      step();
      step();

      // Pointer skip: grant 1, then only 0 and 3
      req_valid = 4'b0010;
      req_data[32 +: 32] = 32'h4110_0000;
      step();
      req_valid = 4'b1001;
      req_data[0 +: 32]  = 32'hC0A0_0000;
      req_data[96 +: 32] = 32'h4049_0FDB;
      step();
`ifndef FPU_ARB_FIXED_PRIO_EN
      check("skip_first", 32'(last_grant), 32'd3);
`endif
      req_valid[last_grant] = 1'b0;
      step();
`ifndef FPU_ARB_FIXED_PRIO_EN
      check("skip_second", 32'(last_grant), 32'd0);
`endif
      req_valid = '0;
      repeat (3) step();

`ifdef FPU_ARB_FIXED_PRIO_EN
      req_valid = 4'b1010;
      req_data[32 +: 32] = 32'h4000_0000;
      req_data[96 +: 32] = 32'h4040_0000;
      for (int c = 0; c < 6; c++) begin
         step();
         check("fixed_prio_grant", 32'(last_grant), 32'd1);
      end
      req_valid = '0;
      repeat (3) step();
`endif

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         drive_random();
         step();
      end
      req_valid = '0;
      repeat (3) step();

      // Reset mid-flight
      req_valid = 4'b0010;
      req_data[32 +: 32] = 32'h40E0_0000;
      step();
      req_valid = '0;
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("midreset_rsp", obs_rsp, 32'd0);
         check("midreset_busy", {31'd0, obs_busy}, 32'd0);
         check("midreset_fux", fu_x, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
